// File: rtl/galaga_lib.sv
// Shared constants and helpers for the galaga game logic.
package galaga_lib;

  localparam int NEP           = 4;
  localparam int EPROJ_SPEED   = 4;
  localparam int EPROJ_W       = 2;
  localparam int EPROJ_H       = 8;
  localparam int SCREEN_BOTTOM = 479;
  localparam int FIRE_COOLDOWN = 20;

  // Unsigned subtract that clamps at zero instead of wrapping.
  function automatic logic [9:0] satSub(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : 10'd0;
  endfunction

endpackage

// File: rtl/enemy_projectile_slot.sv
// One enemy projectile: live flag, sprite position, frame-rate motion and
// per-pixel coverage test for the colour mapper.
module enemy_projectile_slot #(
  parameter int EPROJ_SPEED   = galaga_lib::EPROJ_SPEED,
  parameter int EPROJ_W       = galaga_lib::EPROJ_W,
  parameter int EPROJ_H       = galaga_lib::EPROJ_H,
  parameter int SCREEN_BOTTOM = galaga_lib::SCREEN_BOTTOM
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic       coll,
  input  logic [9:0] fireX,
  input  logic [9:0] fireY,
  input  logic [9:0] drawX,
  input  logic [9:0] drawY,
  output logic       active,
  output logic       on,
  output logic [9:0] distX,
  output logic [9:0] distY
);
  import galaga_lib::*;

  logic [9:0]  posX;
  logic [9:0]  posY;
  logic [10:0] yStep;
  logic        inX;
  logic        inY;

  // Extra bit keeps the bottom-exit test from wrapping back to the top.
  assign yStep = {1'b0, posY} + 11'(EPROJ_SPEED);

  // Slot state: retire on hit or bottom exit, otherwise fall; spawn when picked.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      active <= 1'b0;
      posX   <= '0;
      posY   <= '0;
    end else if (active) begin
      if (coll) begin
        active <= 1'b0;
      end else if (yStep > 11'(SCREEN_BOTTOM)) begin
        active <= 1'b0;
      end else begin
        posY <= yStep[9:0];
      end
    end else if (fire) begin
      active <= 1'b1;
      posX   <= satSub(fireX, 10'(EPROJ_W / 2));
      posY   <= fireY;
    end
  end

  // Sprite coverage and offset of the current pixel, zero when outside.
  always_comb begin
    inX   = ({1'b0, drawX} >= {1'b0, posX}) &&
            ({1'b0, drawX} <  ({1'b0, posX} + 11'(EPROJ_W)));
    inY   = ({1'b0, drawY} >= {1'b0, posY}) &&
            ({1'b0, drawY} <  ({1'b0, posY} + 11'(EPROJ_H)));
    on    = active && inX && inY;
    distX = on ? (drawX - posX) : '0;
    distY = on ? (drawY - posY) : '0;
  end

endmodule

// File: rtl/enemy_projectile_controller.sv
// Pool of enemy projectiles: fire arbitration with cooldown, ship-hit
// reporting and the render offset mux across all slots.
module enemy_projectile_controller #(
  parameter int NEP           = galaga_lib::NEP,
  parameter int EPROJ_SPEED   = galaga_lib::EPROJ_SPEED,
  parameter int EPROJ_W       = galaga_lib::EPROJ_W,
  parameter int EPROJ_H       = galaga_lib::EPROJ_H,
  parameter int SCREEN_BOTTOM = galaga_lib::SCREEN_BOTTOM,
  parameter int FIRE_COOLDOWN = galaga_lib::FIRE_COOLDOWN
) (
  input  logic           frame_clk,
  input  logic           Reset,
  input  logic           FireReq,
  input  logic [9:0]     FireX,
  input  logic [9:0]     FireY,
  input  logic [9:0]     DrawX,
  input  logic [9:0]     DrawY,
  input  logic [NEP-1:0] EProjColl,
  output logic           FireAck,
  output logic           ShipHit,
  output logic [NEP-1:0] EProjOn,
  output logic [9:0]     EProjDistX,
  output logic [9:0]     EProjDistY,
  output logic [NEP-1:0] EProjActive
);
  import galaga_lib::*;

  localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);

  logic [NEP-1:0]  active;
  logic [NEP-1:0]  onVec;
  logic [NEP-1:0]  targetOneHot;
  logic [NEP-1:0]  fireSel;
  logic [9:0]      slotDistX [NEP];
  logic [9:0]      slotDistY [NEP];
  logic [CD_W-1:0] cooldown;
  logic            accept;

  // Lowest-index free slot, judged on the live mask at the start of the frame.
  always_comb begin
    targetOneHot = '0;
    for (int i = NEP - 1; i >= 0; i--) begin
      if (!active[i]) begin
        targetOneHot    = '0;
        targetOneHot[i] = 1'b1;
      end
    end
    accept  = FireReq && (cooldown == '0) && !(&active);
    fireSel = accept ? targetOneHot : '0;
  end

  // Cooldown counter plus the one-frame FireAck and ShipHit pulses.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      cooldown <= '0;
      FireAck  <= 1'b0;
      ShipHit  <= 1'b0;
    end else begin
      FireAck <= accept;
      ShipHit <= |(EProjColl & active);
      if (accept) begin
        cooldown <= CD_W'(FIRE_COOLDOWN);
      end else if (cooldown != '0) begin
        cooldown <= cooldown - CD_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NEP; g++) begin : gSlot
    enemy_projectile_slot #(
      .EPROJ_SPEED  (EPROJ_SPEED),
      .EPROJ_W      (EPROJ_W),
      .EPROJ_H      (EPROJ_H),
      .SCREEN_BOTTOM(SCREEN_BOTTOM)
    ) uSlot (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .fire     (fireSel[g]),
      .coll     (EProjColl[g]),
      .fireX    (FireX),
      .fireY    (FireY),
      .drawX    (DrawX),
      .drawY    (DrawY),
      .active   (active[g]),
      .on       (onVec[g]),
      .distX    (slotDistX[g]),
      .distY    (slotDistY[g])
    );
  end

  assign EProjActive = active;
  assign EProjOn     = onVec;

  // Offset mux: walk high to low so the lowest covering slot wins.
  always_comb begin
    EProjDistX = '0;
    EProjDistY = '0;
    for (int i = NEP - 1; i >= 0; i--) begin
      if (onVec[i]) begin
        EProjDistX = slotDistX[i];
        EProjDistY = slotDistY[i];
      end
    end
  end

endmodule

// File: tb/tb_enemy_projectile_controller.sv
// Directed bench for enemy_projectile_controller: render table plus
// hand-written multi-frame sequences for fire, cooldown, retire and reset.
module tb_enemy_projectile_controller;

  logic       frame_clk;
  logic       Reset;
  logic       FireReq;
  logic [9:0] FireX, FireY, DrawX, DrawY;
  logic [3:0] EProjColl;
  logic       FireAck, ShipHit;
  logic [3:0] EProjOn, EProjActive;
  logic [9:0] EProjDistX, EProjDistY;

  int checks;
  int errors;

  enemy_projectile_controller dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .FireReq    (FireReq),
    .FireX      (FireX),
    .FireY      (FireY),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .EProjColl  (EProjColl),
    .FireAck    (FireAck),
    .ShipHit    (ShipHit),
    .EProjOn    (EProjOn),
    .EProjDistX (EProjDistX),
    .EProjDistY (EProjDistY),
    .EProjActive(EProjActive)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [9:0] dx;
    logic [9:0] dy;
    logic [3:0] expOn;
    logic [9:0] expDx;
    logic [9:0] expDy;
  } pixVec_t;

  pixVec_t pv [8];
  int      ackAt [8];
  int      ackCnt;
  int      expAck [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic doReset;
    Reset     = 1'b1;
    FireReq   = 1'b0;
    EProjColl = 4'b0000;
    tick();
    Reset = 1'b0;
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic [3:0] eOn, input logic [9:0] eDx, input logic [9:0] eDy);
    DrawX = x;
    DrawY = y;
    #1;
    chk({name, "_on"}, 32'(EProjOn), 32'(eOn));
    chk({name, "_dx"}, 32'(EProjDistX), 32'(eDx));
    chk({name, "_dy"}, 32'(EProjDistY), 32'(eDy));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pv[0] = '{10'd319, 10'd100, 4'b0001, 10'd0, 10'd0};
    pv[1] = '{10'd320, 10'd107, 4'b0001, 10'd1, 10'd7};
    pv[2] = '{10'd321, 10'd100, 4'b0000, 10'd0, 10'd0};
    pv[3] = '{10'd318, 10'd100, 4'b0000, 10'd0, 10'd0};
    pv[4] = '{10'd319, 10'd108, 4'b0000, 10'd0, 10'd0};
    pv[5] = '{10'd319, 10'd99,  4'b0000, 10'd0, 10'd0};
    pv[6] = '{10'd320, 10'd103, 4'b0001, 10'd1, 10'd3};
    pv[7] = '{10'd0,   10'd0,   4'b0000, 10'd0, 10'd0};
    expAck = '{0, 21, 42, 63, 96};

    Reset = 1'b1; FireReq = 1'b0; FireX = '0; FireY = '0;
    DrawX = '0; DrawY = '0; EProjColl = '0;
    tick();
    tick();
    // reset state
    chk("rst_ack", 32'(FireAck), 32'd0);
    chk("rst_hit", 32'(ShipHit), 32'd0);
    chk("rst_active", 32'(EProjActive), 32'd0);
    pix("rst_pix", 10'd0, 10'd0, 4'b0000, 10'd0, 10'd0);
    Reset = 1'b0;

    // single shot spawn
    FireReq = 1'b1; FireX = 10'd320; FireY = 10'd100;
    tick();
    FireReq = 1'b0;
    chk("spawn_ack", 32'(FireAck), 32'd1);
    chk("spawn_active", 32'(EProjActive), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      pix($sformatf("tbl%0d", i), pv[i].dx, pv[i].dy, pv[i].expOn, pv[i].expDx, pv[i].expDy);
    end
    tick();
    chk("ack_pulse", 32'(FireAck), 32'd0);
    pix("move104", 10'd319, 10'd104, 4'b0001, 10'd0, 10'd0);
    pix("move103", 10'd319, 10'd103, 4'b0000, 10'd0, 10'd0);
    tick();
    pix("move108", 10'd319, 10'd108, 4'b0001, 10'd0, 10'd0);

    // spawn at left edge clamps to column 0
    doReset();
    FireReq = 1'b1; FireX = 10'd0; FireY = 10'd10;
    tick();
    FireReq = 1'b0;
    pix("sat0", 10'd0, 10'd10, 4'b0001, 10'd0, 10'd0);
    pix("sat1", 10'd1, 10'd10, 4'b0001, 10'd1, 10'd0);

    // held fire request: cooldown spacing and full pool
    doReset();
    FireReq = 1'b1; FireX = 10'd320; FireY = 10'd100;
    ackCnt = 0;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (FireAck) begin
        if (ackCnt < 8) ackAt[ackCnt] = e;
        ackCnt++;
      end
    end
    FireReq = 1'b0;
    chk("hold_ackcnt", 32'(ackCnt), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < ackCnt) chk($sformatf("hold_ack%0d", k), 32'(ackAt[k]), 32'(expAck[k]));
      else chk($sformatf("hold_ack%0d", k), 32'hFFFF_FFFF, 32'(expAck[k]));
    end

    // bottom exit together with a collision
    doReset();
    FireReq = 1'b1; FireX = 10'd101; FireY = 10'd476;
    tick();
    FireReq = 1'b0;
    chk("bot_active", 32'(EProjActive), 32'b0001);
    pix("bot_pix", 10'd100, 10'd476, 4'b0001, 10'd0, 10'd0);
    EProjColl = 4'b0001;
    tick();
    EProjColl = 4'b0000;
    chk("bot_retire", 32'(EProjActive), 32'd0);
    chk("bot_hit", 32'(ShipHit), 32'd1);
    pix("bot_gone", 10'd100, 10'd476, 4'b0000, 10'd0, 10'd0);
    pix("bot_nowrap", 10'd100, 10'd0, 4'b0000, 10'd0, 10'd0);
    tick();
    chk("bot_hitpulse", 32'(ShipHit), 32'd0);

    // last row reachable, then exit
    doReset();
    FireReq = 1'b1; FireX = 10'd101; FireY = 10'd475;
    tick();
    FireReq = 1'b0;
    tick();
    chk("edge_active", 32'(EProjActive), 32'b0001);
    pix("edge_479", 10'd100, 10'd479, 4'b0001, 10'd0, 10'd0);
    tick();
    chk("edge_retire", 32'(EProjActive), 32'd0);
    chk("edge_nohit", 32'(ShipHit), 32'd0);
    pix("edge_top", 10'd100, 10'd3, 4'b0000, 10'd0, 10'd0);

    // overlap priority and collisions on live / idle slots
    doReset();
    FireReq = 1'b1; FireX = 10'd320; FireY = 10'd100;
    repeat (21) tick();
    FireY = 10'd186;
    tick();
    FireReq = 1'b0;
    chk("coll_active", 32'(EProjActive), 32'b0011);
    pix("overlap", 10'd320, 10'd188, 4'b0011, 10'd1, 10'd4);
    EProjColl = 4'b0010;
    tick();
    EProjColl = 4'b0000;
    chk("coll_hit", 32'(ShipHit), 32'd1);
    chk("coll_retire", 32'(EProjActive), 32'b0001);
    tick();
    chk("coll_hitpulse", 32'(ShipHit), 32'd0);
    EProjColl = 4'b0100;
    tick();
    EProjColl = 4'b0000;
    chk("idle_nohit", 32'(ShipHit), 32'd0);
    chk("idle_active", 32'(EProjActive), 32'b0001);

    // full pool, slot 0 retires in the same frame as a request
    doReset();
    FireReq = 1'b1; FireX = 10'd320; FireY = 10'd100;
    repeat (85) tick();
    chk("full_active", 32'(EProjActive), 32'b1111);
    FireX = 10'd50; FireY = 10'd200;
    EProjColl = 4'b0001;
    tick();
    EProjColl = 4'b0000;
    chk("full_noack", 32'(FireAck), 32'd0);
    chk("full_hit", 32'(ShipHit), 32'd1);
    chk("full_freed", 32'(EProjActive), 32'b1110);
    tick();
    FireReq = 1'b0;
    chk("reuse_ack", 32'(FireAck), 32'd1);
    chk("reuse_active", 32'(EProjActive), 32'b1111);
    pix("reuse_pix", 10'd49, 10'd200, 4'b0001, 10'd0, 10'd0);

    // reset mid-flight with three shots and cooldown pending
    doReset();
    FireReq = 1'b1; FireX = 10'd320; FireY = 10'd100;
    repeat (43) tick();
    FireReq = 1'b0;
    repeat (10) tick();
    chk("mid_active", 32'(EProjActive), 32'b0111);
    pix("mid_pix", 10'd319, 10'd308, 4'b0001, 10'd0, 10'd0);
    Reset = 1'b1; FireReq = 1'b1; EProjColl = 4'b0111;
    tick();
    chk("mid_rst_ack", 32'(FireAck), 32'd0);
    chk("mid_rst_hit", 32'(ShipHit), 32'd0);
    chk("mid_rst_active", 32'(EProjActive), 32'd0);
    pix("mid_rst_pix", 10'd319, 10'd308, 4'b0000, 10'd0, 10'd0);
    Reset = 1'b0; EProjColl = 4'b0000;
    tick();
    FireReq = 1'b0;
    chk("post_rst_ack", 32'(FireAck), 32'd1);
    chk("post_rst_active", 32'(EProjActive), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
